// File: rtl/mult_rr_scheduler.sv
// Round-robin front end that shares one serial shift-and-add multiplier among NUM_REQ clients.
// Optional watchdog on the multiplier's done is enabled by defining MULT_TIMEOUT_EN.
module mult_rr_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_W       = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_W-1:0]               resp_id,
    output logic [2*DATA_WIDTH-1:0]       resp_product,
    output logic                          mult_start,
    output logic [DATA_WIDTH-1:0]         mult_data,
    input  logic                          mult_done,
    input  logic [DATA_WIDTH-1:0]         mult_prod_hi,
    input  logic [DATA_WIDTH-1:0]         mult_prod_lo,
    output logic                          busy,
    output logic                          resp_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_B = 3'd1,
        S_LOAD_A = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                  r_state;
    logic [ID_W-1:0]         r_last_grant;
    logic [ID_W-1:0]         r_gnt_id;
    logic [DATA_WIDTH-1:0]   r_op_a;
    logic                    r_resp_valid;
    logic [ID_W-1:0]         r_resp_id;
    logic [2*DATA_WIDTH-1:0] r_resp_product;
    logic                    r_mult_start;
    logic [DATA_WIDTH-1:0]   r_mult_data;
    logic                    r_busy;

    logic                    w_any;
    logic [ID_W-1:0]         w_gidx;
    int                      w_best;
    int                      w_dist;
    logic [DATA_WIDTH-1:0]   w_sel_a;
    logic [DATA_WIDTH-1:0]   w_sel_b;

    // Winner is the valid requester at the smallest rotational distance past last_grant.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_best = NUM_REQ;
        w_dist = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = (j + NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ;
            if (req_valid[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_gidx = ID_W'(j);
                w_any  = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gidx == ID_W'(k)) begin
                w_sel_a      = req_a[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_b      = req_b[k*DATA_WIDTH +: DATA_WIDTH];
                req_ready[k] = (r_state == S_IDLE) && w_any;
            end
        end
    end

`ifdef MULT_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wd;
    logic            r_err;
    logic            w_timeout;

    // Counter sits at zero outside WAIT, so it is already cleared on entry.
    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state != S_WAIT)) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && (r_wd == WD_W'(TIMEOUT - 1));
    assign resp_err  = r_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT > 0);
    assign resp_err     = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_last_grant   <= ID_W'(NUM_REQ - 1);
            r_gnt_id       <= '0;
            r_op_a         <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_id      <= '0;
            r_resp_product <= '0;
            r_mult_start   <= 1'b0;
            r_mult_data    <= '0;
            r_busy         <= 1'b0;
`ifdef MULT_TIMEOUT_EN
            r_err          <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt_id     <= w_gidx;
                        r_op_a       <= w_sel_a;
                        r_mult_start <= 1'b1;
                        r_mult_data  <= w_sel_b;
                        r_busy       <= 1'b1;
                        r_state      <= S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    r_mult_start <= 1'b0;
                    r_mult_data  <= r_op_a;
                    r_state      <= S_LOAD_A;
                end
                S_LOAD_A: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mult_done) begin
                        r_resp_product <= {mult_prod_hi, mult_prod_lo};
                        r_resp_id      <= r_gnt_id;
                        r_resp_valid   <= 1'b1;
                        r_state        <= S_RESP;
`ifdef MULT_TIMEOUT_EN
                        r_err          <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp_product <= '0;
                        r_resp_id      <= r_gnt_id;
                        r_resp_valid   <= 1'b1;
                        r_err          <= 1'b1;
                        r_state        <= S_RESP;
`endif
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_last_grant <= r_gnt_id;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
`ifdef MULT_TIMEOUT_EN
                        r_err        <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_id      = r_resp_id;
    assign resp_product = r_resp_product;
    assign mult_start   = r_mult_start;
    assign mult_data    = r_mult_data;
    assign busy         = r_busy;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: directed and random jobs against a round-robin/product reference,
// with a behavioural serial multiplier answering the scheduler.
module tb_mult_rr_scheduler;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TO = 64;

    logic              i_clk;
    logic              i_rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_a;
    logic [NR*DW-1:0]  req_b;
    logic [NR-1:0]     req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [1:0]        resp_id;
    logic [2*DW-1:0]   resp_product;
    logic              mult_start;
    logic [DW-1:0]     mult_data;
    logic              mult_done;
    logic [DW-1:0]     mult_prod_hi;
    logic [DW-1:0]     mult_prod_lo;
    logic              busy;
    logic              resp_err;

    int checks = 0;
    int errors = 0;
    int last_g = NR - 1;

    int          mm_lat = 2;
    bit          mm_en  = 1'b1;
    int          mm_phase = 0;
    int          mm_cnt = 0;
    logic [7:0]  mm_a, mm_b;

    mult_rr_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_W(2), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_product(resp_product),
        .mult_start(mult_start), .mult_data(mult_data), .mult_done(mult_done),
        .mult_prod_hi(mult_prod_hi), .mult_prod_lo(mult_prod_lo),
        .busy(busy), .resp_err(resp_err)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Serial multiplier: B rides the bus with start, A the cycle after, done mm_lat cycles later.
    initial begin
        mult_done    = 1'b0;
        mult_prod_hi = '0;
        mult_prod_lo = '0;
        forever begin
            @(negedge i_clk);
            mult_done = 1'b0;
            if (mult_start) begin
                mm_b     = mult_data;
                mm_phase = 1;
            end else if (mm_phase == 1) begin
                mm_a     = mult_data;
                mm_cnt   = mm_lat;
                mm_phase = 2;
            end else if (mm_phase == 2) begin
                if (mm_cnt == 0) begin
                    if (mm_en) begin
                        mult_done = 1'b1;
                        {mult_prod_hi, mult_prod_lo} = 16'(int'(mm_a) * int'(mm_b));
                    end
                    mm_phase = 0;
                end else begin
                    mm_cnt--;
                end
            end
        end
    end

    function automatic int rr_pick(input int last, input logic [NR-1:0] v);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the response handshake.
    task automatic run_job(input logic [NR-1:0] vm, input logic [31:0] av, input logic [31:0] bv,
                           input int hold, input bit drop, input bit early);
        int g;
        int n;
        logic [7:0] ea, eb;
        g  = rr_pick(last_g, vm);
        ea = av[g*8 +: 8];
        eb = bv[g*8 +: 8];
        req_a     = av;
        req_b     = bv;
        req_valid = vm;
        #1;
        chk("req_ready_grant", 32'(req_ready), 32'(1 << g));
        chk("busy_idle", 32'(busy), 32'd0);
        @(negedge i_clk);
        req_a = $urandom();
        req_b = $urandom();
        if (drop) req_valid = '0;
        if (early) resp_ready = 1'b1;
        chk("start_load_b", 32'(mult_start), 32'd1);
        chk("data_load_b", 32'(mult_data), 32'(eb));
        chk("req_ready_after", 32'(req_ready), 32'd0);
        chk("busy_load", 32'(busy), 32'd1);
        @(negedge i_clk);
        chk("start_load_a", 32'(mult_start), 32'd0);
        chk("data_load_a", 32'(mult_data), 32'(ea));
        n = 0;
        while (!resp_valid && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        chk("resp_seen", 32'(resp_valid), 32'd1);
        chk("resp_id", 32'(resp_id), 32'(g));
        chk("resp_product", 32'(resp_product), 32'(int'(ea) * int'(eb)));
        chk("resp_err", 32'(resp_err), 32'd0);
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge i_clk);
                chk("hold_valid", 32'(resp_valid), 32'd1);
                chk("hold_id", 32'(resp_id), 32'(g));
                chk("hold_product", 32'(resp_product), 32'(int'(ea) * int'(eb)));
                chk("hold_no_grant", 32'(req_ready), 32'd0);
                chk("hold_busy", 32'(busy), 32'd1);
            end
            resp_ready = 1'b1;
        end
        @(negedge i_clk);
        resp_ready = 1'b0;
        chk("resp_drop", 32'(resp_valid), 32'd0);
        chk("busy_drop", 32'(busy), 32'd0);
        last_g = g;
    endtask

    initial begin
        int n;
        int g;
        logic [NR-1:0] vm;
        bit early;
        i_rst      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;

        repeat (3) @(negedge i_clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_product", 32'(resp_product), 32'd0);
        chk("rst_mult_start", 32'(mult_start), 32'd0);
        chk("rst_mult_data", 32'(mult_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        i_rst = 1'b0;

        // Idle with no requests
        repeat (3) begin
            @(negedge i_clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_start", 32'(mult_start), 32'd0);
        end

        // 5 x 3 on requester 0
        mm_lat = 3;
        run_job(4'b0001, 32'h0000_0005, 32'h0000_0003, 2, 1'b1, 1'b0);

        // All requesters held, response always ready
        for (int i = 0; i < 5; i++) begin
            mm_lat = i;
            run_job(4'b1111, $urandom(), $urandom(), 0, 1'b0, 1'b1);
        end

        // Largest operands on requester 2, then a long response stall
        run_job(4'b0100, 32'h00FF_0000, 32'h00FF_0000, 1, 1'b1, 1'b0);
        run_job(4'b0110, $urandom(), $urandom(), 10, 1'b1, 1'b0);

        // Reset in the middle of a multiply
        mm_lat    = 30;
        req_a     = $urandom();
        req_b     = $urandom();
        req_valid = 4'b0010;
        @(negedge i_clk);
        req_valid = '0;
        @(negedge i_clk);
        repeat (3) @(negedge i_clk);
        chk("busy_in_wait", 32'(busy), 32'd1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_data", 32'(mult_data), 32'd0);
        chk("mid_rst_start", 32'(mult_start), 32'd0);
        chk("mid_rst_id", 32'(resp_id), 32'd0);
        last_g = NR - 1;
        mm_lat = 1;
        run_job(4'b1001, $urandom(), $urandom(), 0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            mm_lat = $urandom_range(0, 6);
            vm     = NR'($urandom_range(1, 15));
            early  = bit'($urandom_range(0, 1));
            run_job(vm, $urandom(), $urandom(), early ? 0 : int'($urandom_range(0, 3)),
                    bit'($urandom_range(0, 1)), early);
        end
        req_valid = '0;

`ifdef MULT_TIMEOUT_EN
        // Multiplier never answers: watchdog must produce an error response
        mm_en     = 1'b0;
        g         = rr_pick(last_g, 4'b0001);
        req_a     = $urandom();
        req_b     = $urandom();
        req_valid = 4'b0001;
        @(negedge i_clk);
        req_valid = '0;
        @(negedge i_clk);
        n = 0;
        while (!resp_valid && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        chk("to_cycles", 32'(n), 32'(TO + 1));
        chk("to_err", 32'(resp_err), 32'd1);
        chk("to_product", 32'(resp_product), 32'd0);
        chk("to_id", 32'(resp_id), 32'(g));
        resp_ready = 1'b1;
        @(negedge i_clk);
        resp_ready = 1'b0;
        chk("to_err_clear", 32'(resp_err), 32'd0);
        chk("to_valid_clear", 32'(resp_valid), 32'd0);
        last_g = g;
        mm_en  = 1'b1;
`else
        n = 0;
        g = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
Round-robin scheduler that shares one 8-bit shift-and-add sequential multiplier among NUM_REQ requesters. It arbitrates requests and latches the winner's operands. It sequences the multiplier's start and serial operand load (multiplicand B, then multiplier A), waits for the multiplier's done, and returns the 16-bit product with the requester ID over a valid/ready response port. It sits between the client logic and the multiplier top; it is the only driver of the multiplier's start and data_input.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, operand width; product is 2*DATA_WIDTH
ID_W, 2, requester ID width; must satisfy 2**ID_W >= NUM_REQ
TIMEOUT, 64, watchdog limit in cycles (used only with MULT_TIMEOUT_EN)

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester request
req_a  in  NUM_REQ*DATA_WIDTH  multiplier operands, requester k in slice k
req_b  in  NUM_REQ*DATA_WIDTH  multiplicand operands, requester k in slice k
req_ready  out  NUM_REQ  one-hot single-cycle accept pulse
resp_valid  out  1  product available
resp_ready  in  1  consumer accepts response
resp_id  out  ID_W  requester index of the response
resp_product  out  2*DATA_WIDTH  {hi,lo} product
mult_start  out  1  start strobe to multiplier
mult_data  out  DATA_WIDTH  serial operand bus to multiplier data_input
mult_done  in  1  multiplier completion
mult_prod_hi  in  DATA_WIDTH  multiplier accumulator register (product high byte)
mult_prod_lo  in  DATA_WIDTH  multiplier A register (product low byte)
busy  out  1  high in every state except IDLE
resp_err  out  1  timeout flag qualified by resp_valid (tied 0 without feature)

Behaviour:
- Reset (i_rst=1 at edge, any state, including mid-multiply): state=IDLE; req_ready=0, resp_valid=0, resp_id=0, resp_product=0, mult_start=0, mult_data=0, busy=0, resp_err=0. Round-robin pointer last_grant is set to NUM_REQ-1, so requester 0 has first priority. The multiplier is not separately reset; a new job re-issues mult_start.
- States: IDLE, LOAD_B, LOAD_A, WAIT, RESP.
- IDLE: if any req_valid, grant g = first set bit scanning (last_grant+1) mod NUM_REQ upward with wrap. In the same cycle req_ready[g]=1 (combinational, one cycle) and req_a/req_b slice g is latched at the edge. Next state is LOAD_B. With no request, stay in IDLE.
- LOAD_B (1 cycle): mult_start=1, mult_data=latched B. Next state is LOAD_A.
- LOAD_A (1 cycle): mult_start=0, mult_data=latched A. Next state is WAIT.
- WAIT: mult_data holds A. On mult_done=1, capture {mult_prod_hi,mult_prod_lo} into resp_product and g into resp_id, then go to RESP.
- RESP: resp_valid=1; resp_id and resp_product are held stable until resp_ready=1. On the handshake edge: resp_valid drops next cycle, last_grant=g, go to IDLE.
- Throughput: 1 accept cycle + 2 load cycles + multiplier latency + at least 1 response cycle. There is no back-to-back overlap; the next grant can occur in the cycle after the RESP handshake.
- mult_done is ignored outside WAIT. mult_done asserted in the first WAIT cycle is legal and is captured.
- req_valid deasserting after grant has no effect; operands are already latched. req_valid on non-granted requesters is ignored until IDLE.
- The product is unsigned: 8x8 gives 16 bits, so 0xFF*0xFF = 0xFE01. Arbiter wrap: with last_grant=NUM_REQ-1, the scan starts at 0.
- resp_ready asserted while resp_valid=0 has no effect.

Optional Feature:
MULT_TIMEOUT_EN
- With: a counter clears on entering WAIT and increments each WAIT cycle. If it reaches TIMEOUT without mult_done, go to RESP with resp_product=0 and resp_err=1. resp_err clears on the RESP handshake or on reset.
- Without: WAIT waits indefinitely, no counter is synthesized, and resp_err is tied to 0.

Test Plan:
- Reset then req_valid=0001, a0=0x05, b0=0x03: req_ready=0001 for 1 cycle. mult_start high 1 cycle with mult_data=0x03, next cycle mult_data=0x05. After model done: resp_valid=1, resp_id=0, resp_product=0x000F.
- All req_valid=1111 held, resp_ready=1: grants in order 0,1,2,3,0 and resp_id follows the same sequence.
- Operands 0xFF*0xFF on requester 2: resp_product=0xFE01, resp_id=2.
- resp_ready held 0 for 10 cycles in RESP: resp_valid, resp_id and resp_product stay stable, busy=1, and no req_ready pulses. Release gives one handshake followed by a new grant.
- Assert i_rst during WAIT: next cycle all outputs are at reset values. A subsequent request from requester 3 with requester 0 also valid grants requester 0 first.
- MULT_TIMEOUT_EN, TIMEOUT=64, mult_done never asserted: resp_valid rises after 64 WAIT cycles with resp_err=1 and resp_product=0x0000.
